// File: rtl/prod_acc_requant_if.sv
// Product-in / pixel-out handshake bundle for the window accumulator and requantiser.
// The slave modport is the accumulator; the master modport is the surrounding datapath.
interface prod_acc_requant_if #(
  parameter int PIX_BIT    = 8,
  parameter int COFCNT_BIT = 16
);
  localparam int PW = PIX_BIT + COFCNT_BIT;

  logic                 p_valid;
  logic                 p_ready;
  logic signed [PW-1:0] p;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [PIX_BIT-1:0]   pix;
  logic                 sat;

  modport master (
    output p_valid, p, pix_ready,
    input  p_ready, pix_valid, pix, sat
  );

  modport slave (
    input  p_valid, p, pix_ready,
    output p_ready, pix_valid, pix, sat
  );
endinterface

// File: rtl/prod_acc_requant.sv
// Sums TAPS signed A(8,15) products per window, then rounds half-up, drops the fraction
// and saturates to an unsigned U(8,0) pixel held in a valid/ready output register.
module prod_acc_requant #(
  parameter int PIX_BIT    = 8,
  parameter int COFCNT_BIT = 16,
  parameter int TAPS       = 9,
  parameter int GUARD      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  prod_acc_requant_if.slave       bus
);
  localparam int PW = PIX_BIT + COFCNT_BIT;
  localparam int FB = COFCNT_BIT - 1;
  localparam int AW = PW + GUARD;
  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [CW-1:0]        TAP_LAST = CW'(TAPS - 1);
  localparam logic signed [AW-1:0] HALF     = AW'(1) <<< (FB - 1);
  localparam logic signed [AW-1:0] PIX_MAX  = AW'((1 << PIX_BIT) - 1);

  function automatic logic signed [AW-1:0] round_half_up(input logic signed [AW-1:0] s);
    return (s + HALF) >>> FB;
  endfunction

  // Returns {sat, pix}.
  function automatic logic [PIX_BIT:0] saturate(input logic signed [AW-1:0] r);
    if (r[AW-1])
      return {1'b1, {PIX_BIT{1'b0}}};
    else if (r > PIX_MAX)
      return {1'b1, {PIX_BIT{1'b1}}};
    else
      return {1'b0, r[PIX_BIT-1:0]};
  endfunction

  logic signed [AW-1:0] acc_p0;
  logic [CW-1:0]        tap_cnt_p0;
  logic [PIX_BIT-1:0]   pix_p1;
  logic                 sat_p1;
  logic                 vld_p1;

  logic signed [AW-1:0] p_ext;
  logic signed [AW-1:0] sum;
  logic [PIX_BIT:0]     requant;
  logic                 accept;
  logic                 complete;

  assign bus.p_ready = !(vld_p1 && !bus.pix_ready);
  assign accept      = bus.p_valid && bus.p_ready;
  assign complete    = accept && !clr && (tap_cnt_p0 == TAP_LAST);

  assign p_ext   = {{GUARD{bus.p[PW-1]}}, bus.p};
  assign sum     = acc_p0 + p_ext;
  assign requant = saturate(round_half_up(sum));

  // Stage p0: window accumulation; clr restarts the window, a coincident product becomes tap 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_p0     <= '0;
      tap_cnt_p0 <= '0;
    end else if (clr) begin
      acc_p0     <= accept ? p_ext : '0;
      tap_cnt_p0 <= accept ? CW'(1) : '0;
    end else if (accept) begin
      if (tap_cnt_p0 == '0) begin
        acc_p0     <= p_ext;
        tap_cnt_p0 <= CW'(1);
      end else if (tap_cnt_p0 == TAP_LAST) begin
        acc_p0     <= '0;
        tap_cnt_p0 <= '0;
      end else begin
        acc_p0     <= sum;
        tap_cnt_p0 <= tap_cnt_p0 + CW'(1);
      end
    end
  end

  // Stage p1: output pixel register; a completing window may reload it in the cycle it is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_p1 <= '0;
      sat_p1 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (complete) begin
      pix_p1 <= requant[PIX_BIT-1:0];
      sat_p1 <= requant[PIX_BIT];
      vld_p1 <= 1'b1;
    end else if (vld_p1 && bus.pix_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.pix       = pix_p1;
  assign bus.sat       = sat_p1;
  assign bus.pix_valid = vld_p1;
endmodule

// File: doc/prod_acc_requant.md
# prod_acc_requant

Window accumulator and requantiser that closes the filter datapath. It takes the registered signed pixel×coefficient products, format A(8,15), for one filter window and sums exactly TAPS of them. It then rounds, drops the 15 fraction bits and saturates the result back to an unsigned U(8,0) output pixel. It sits directly after the bank of signed multipliers and drives the output-pixel stream under a valid/ready handshake.

## Interface
- PIX_BIT, 8: output pixel width, U(PIX_BIT,0).
- COFCNT_BIT, 16: coefficient width, A(0,COFCNT_BIT-1).
  - Product width is PW = PIX_BIT+COFCNT_BIT (24).
  - Fraction bits are FB = COFCNT_BIT-1 (15).
- TAPS, 9: number of products per window; must be ≥2.
- GUARD, 4: accumulator guard bits, with 2^GUARD ≥ TAPS. Accumulator width is AW = PW+GUARD (28), signed.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous window restart; does not touch the output register.
- p_valid  in  1  product on p is valid.
- p_ready  out  1  block accepts a product this cycle.
- p  in  PW  signed product, A(8,15).
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accepts the pixel.
- pix  out  PIX_BIT  unsigned result pixel, registered.
- sat  out  1  registered flag qualifying pix; 1 means pix was clipped.

## Operation
- Accept condition: a product is accepted when p_valid && p_ready.
- p_ready is combinational: p_ready = !(pix_valid && !pix_ready).
- Tap counter tap_cnt runs 0..TAPS-1 and advances only on an accept.
- Accepted product with tap_cnt==0: acc <= sign-extended p.
- Accepted product with 0<tap_cnt<TAPS-1: acc <= acc + sign-extended p.
- Accepted product with tap_cnt==TAPS-1 (window complete):
  - sum = acc + p, computed at AW bits.
  - r = (sum + 2^(FB-1)) >>> FB, arithmetic shift; rounding is round-half-up.
  - r < 0: pix <= 0, sat <= 1.
  - r > 2^PIX_BIT-1: pix <= 2^PIX_BIT-1, sat <= 1.
  - otherwise: pix <= r[PIX_BIT-1:0], sat <= 0.
  - pix_valid <= 1 and tap_cnt <= 0.
- Output handshake:
  - pix, sat and pix_valid hold while pix_valid && !pix_ready.
  - On pix_valid && pix_ready with no new window completing: pix_valid <= 0.
  - A new window completing in the same cycle as a pixel is taken loads the new result, and pix_valid stays 1.
- clr:
  - tap_cnt <= 0 and acc <= 0, overriding any accumulation that cycle.
  - If a product is accepted in the same cycle, it becomes tap 0 of a new window: acc <= p, tap_cnt <= 1.
  - pix, sat and pix_valid are unaffected.
- Overflow: AW bits cannot overflow for TAPS ≤ 2^GUARD; no wrap handling is required.
- Reset (async, any time, including mid-window):
  - tap_cnt = 0, acc = 0, pix_valid = 0, pix = 0, sat = 0.
  - The partial window is discarded.

## Timing
- Throughput: one product per cycle when not stalled; a window of TAPS products takes TAPS accept cycles.
- Latency: pix_valid rises on the clock edge that accepts the TAPS-th product, so it is visible in the following cycle. The result is available one cycle after the last product.
- Stall: p_ready falls in the same cycle pix_valid is high and pix_ready is low. p_ready returns combinationally when pix_ready rises.
- Upstream rule: the producer must hold p stable while p_valid && !p_ready.
- Back-to-back windows with pix_ready held at 1 give a pix_valid pulse every TAPS cycles with no bubbles.

## Test plan
- Box filter, all 9 taps carry p = 100×3641 = 364100 -> sum 3276900 -> pix = 100, sat = 0, pix_valid one cycle after the 9th accept.
- Rounding:
  - Tap 0 p = 16384, taps 1-8 p = 0 -> pix = 1, sat = 0.
  - Repeat with tap 0 p = 16383 -> pix = 0, sat = 0.
- Saturation:
  - Tap 0 p = -1638400, rest 0 -> pix = 0, sat = 1.
  - All 9 taps p = 255×32767 = 8355585 -> pix = 255, sat = 1.
- Backpressure:
  - Hold pix_ready = 0 after a window completes -> pix and sat hold, p_ready = 0, tap_cnt frozen despite p_valid = 1.
  - Raise pix_ready -> p_ready = 1 in the same cycle, and the next window accumulates correctly.
- Reset mid-window: accept 4 taps of 364100, pull reset low for 1 cycle -> all outputs 0.
  - Then 9 taps of 364100 -> pix = 100; the 4 earlier taps do not contribute.
- clr with a coincident product:
  - Accept 5 taps of 1000000, then assert clr together with p = 364100.
  - Then 8 further taps of 364100 -> pix = 100, with pix_valid after the 8th further accept.
  - clr while pix_valid = 1 leaves pix unchanged.
